// File: rtl/logic_axi4_stream_transfer_counter_if.sv
// rtl/logic_axi4_stream_transfer_counter_if.sv - AXI4-Stream link bundle with master/slave views
interface logic_axi4_stream_transfer_counter_if #(
    parameter int TDATA_BYTES = 4,
    parameter int TDEST_WIDTH = 2,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1
);
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic [TDATA_BYTES*8-1:0] tdata;
    logic [TDATA_BYTES-1:0]   tstrb;
    logic [TDATA_BYTES-1:0]   tkeep;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TID_WIDTH-1:0]     tid;

    modport master (
        output tvalid, tlast, tdata, tstrb, tkeep, tdest, tuser, tid,
        input  tready
    );

    modport slave (
        input  tvalid, tlast, tdata, tstrb, tkeep, tdest, tuser, tid,
        output tready
    );
endinterface

// File: rtl/logic_axi4_stream_transfer_counter.sv
// rtl/logic_axi4_stream_transfer_counter.sv - in-line AXI4-Stream monitor with per-TDEST beat/byte/packet counters
module logic_axi4_stream_transfer_counter #(
    parameter int TDATA_BYTES   = 4,
    parameter int TDEST_WIDTH   = 2,
    parameter int TUSER_WIDTH   = 1,
    parameter int TID_WIDTH     = 1,
    parameter int CHANNELS      = 4,
    parameter int COUNTER_WIDTH = 32,
    parameter int SATURATE      = 1,
    localparam int IDXW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW           = COUNTER_WIDTH
) (
    input  logic                                  aclk,
    input  logic                                  areset,
    logic_axi4_stream_transfer_counter_if.slave   rx,
    logic_axi4_stream_transfer_counter_if.master  tx,
    input  logic                                  cnt_read,
    input  logic                                  cnt_clear,
    input  logic                                  cnt_clear_all,
    input  logic [IDXW-1:0]                       cnt_channel,
    output logic                                  cnt_valid,
    output logic [CW-1:0]                         cnt_beats,
    output logic [CW-1:0]                         cnt_bytes,
    output logic [CW-1:0]                         cnt_packets,
    output logic                                  cnt_overflow
);
    assign tx.tvalid = rx.tvalid;
    assign tx.tlast  = rx.tlast;
    assign tx.tdata  = rx.tdata;
    assign tx.tstrb  = rx.tstrb;
    assign tx.tkeep  = rx.tkeep;
    assign tx.tdest  = rx.tdest;
    assign tx.tuser  = rx.tuser;
    assign tx.tid    = rx.tid;
    assign rx.tready = tx.tready;

    logic            w_xfer;
    logic [IDXW-1:0] w_idx;
    logic [CW-1:0]   w_keep_cnt;

    logic [CW-1:0] r_beats   [CHANNELS];
    logic [CW-1:0] r_bytes   [CHANNELS];
    logic [CW-1:0] r_packets [CHANNELS];
    logic          r_ovf     [CHANNELS];

    logic [CW-1:0] w_inc_beats [CHANNELS];
    logic [CW-1:0] w_inc_bytes [CHANNELS];
    logic [CW-1:0] w_inc_pkts  [CHANNELS];
    logic [CW-1:0] w_nxt_beats [CHANNELS];
    logic [CW-1:0] w_nxt_bytes [CHANNELS];
    logic [CW-1:0] w_nxt_pkts  [CHANNELS];
    logic          w_nxt_ovf   [CHANNELS];
    logic          w_clr       [CHANNELS];
    logic          w_snap      [CHANNELS];

    assign w_xfer = rx.tvalid && tx.tready;
    assign w_idx  = (CHANNELS == 1) ? '0 : rx.tdest[IDXW-1:0];

    function automatic logic [CW:0] f_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        f_add = {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [CW-1:0] f_fold(input logic [CW:0] s);
        f_fold = (SATURATE != 0 && s[CW]) ? '1 : s[CW-1:0];
    endfunction

    always_comb begin
        w_keep_cnt = '0;
        for (int i = 0; i < TDATA_BYTES; i++) begin
            w_keep_cnt = w_keep_cnt + CW'(rx.tkeep[i]);
        end
    end

    always_comb begin
        logic          v_hit;
        logic [CW:0]   v_b;
        logic [CW:0]   v_y;
        logic [CW:0]   v_p;
        v_hit = 1'b0;
        v_b   = '0;
        v_y   = '0;
        v_p   = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_hit          = w_xfer && (w_idx == IDXW'(c));
            w_inc_beats[c] = CW'(v_hit);
            w_inc_bytes[c] = v_hit ? w_keep_cnt : '0;
            w_inc_pkts[c]  = CW'(v_hit && rx.tlast);
            v_b            = f_add(r_beats[c], w_inc_beats[c]);
            v_y            = f_add(r_bytes[c], w_inc_bytes[c]);
            v_p            = f_add(r_packets[c], w_inc_pkts[c]);
            w_nxt_beats[c] = f_fold(v_b);
            w_nxt_bytes[c] = f_fold(v_y);
            w_nxt_pkts[c]  = f_fold(v_p);
            w_nxt_ovf[c]   = r_ovf[c] | v_b[CW] | v_y[CW] | v_p[CW];
            w_snap[c]      = cnt_read && (cnt_channel == IDXW'(c));
            w_clr[c]       = cnt_clear_all || (w_snap[c] && cnt_clear);
        end
    end

    // A cleared channel keeps a same-cycle increment unless the snapshot already consumed it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_beats[c]   <= '0;
                r_bytes[c]   <= '0;
                r_packets[c] <= '0;
                r_ovf[c]     <= 1'b0;
            end
            cnt_valid    <= 1'b0;
            cnt_beats    <= '0;
            cnt_bytes    <= '0;
            cnt_packets  <= '0;
            cnt_overflow <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_clr[c]) begin
                    r_beats[c]   <= w_snap[c] ? '0 : w_inc_beats[c];
                    r_bytes[c]   <= w_snap[c] ? '0 : w_inc_bytes[c];
                    r_packets[c] <= w_snap[c] ? '0 : w_inc_pkts[c];
                    r_ovf[c]     <= 1'b0;
                end else begin
                    r_beats[c]   <= w_nxt_beats[c];
                    r_bytes[c]   <= w_nxt_bytes[c];
                    r_packets[c] <= w_nxt_pkts[c];
                    r_ovf[c]     <= w_nxt_ovf[c];
                end
            end
            cnt_valid <= cnt_read;
            if (cnt_read) begin
                cnt_beats    <= w_nxt_beats[cnt_channel];
                cnt_bytes    <= w_nxt_bytes[cnt_channel];
                cnt_packets  <= w_nxt_pkts[cnt_channel];
                cnt_overflow <= w_nxt_ovf[cnt_channel];
            end
        end
    end
endmodule

// File: tb/tb_logic_axi4_stream_transfer_counter.sv
// tb/tb_logic_axi4_stream_transfer_counter.sv - directed bench for the stream transfer counter
module tb_logic_axi4_stream_transfer_counter;
    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    logic        s_tvalid, s_tlast, s_tx_tready;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep, s_tstrb;
    logic [1:0]  s_tdest;
    logic        s_tuser, s_tid;
    logic        cnt_read, cnt_clear, cnt_clear_all;
    logic [1:0]  cnt_channel;

    int n_tests = 0;
    int n_fail  = 0;

    logic_axi4_stream_transfer_counter_if #(.TDATA_BYTES(4), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) rxa [3] ();
    logic_axi4_stream_transfer_counter_if #(.TDATA_BYTES(4), .TDEST_WIDTH(2), .TUSER_WIDTH(1), .TID_WIDTH(1)) txa [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_drv
        assign rxa[g].tvalid = s_tvalid;
        assign rxa[g].tlast  = s_tlast;
        assign rxa[g].tdata  = s_tdata;
        assign rxa[g].tkeep  = s_tkeep;
        assign rxa[g].tstrb  = s_tstrb;
        assign rxa[g].tdest  = s_tdest;
        assign rxa[g].tuser  = s_tuser;
        assign rxa[g].tid    = s_tid;
        assign txa[g].tready = s_tx_tready;
    end

    logic        v0, v1, v2, o0, o1, o2;
    logic [31:0] b0, y0, p0;
    logic [7:0]  b1, y1, p1, b2, y2, p2;

    logic_axi4_stream_transfer_counter u0 (
        .aclk(aclk), .areset(areset), .rx(rxa[0]), .tx(txa[0]),
        .cnt_read(cnt_read), .cnt_clear(cnt_clear), .cnt_clear_all(cnt_clear_all),
        .cnt_channel(cnt_channel), .cnt_valid(v0), .cnt_beats(b0), .cnt_bytes(y0),
        .cnt_packets(p0), .cnt_overflow(o0));

    logic_axi4_stream_transfer_counter #(.COUNTER_WIDTH(8), .SATURATE(1)) u1 (
        .aclk(aclk), .areset(areset), .rx(rxa[1]), .tx(txa[1]),
        .cnt_read(cnt_read), .cnt_clear(cnt_clear), .cnt_clear_all(cnt_clear_all),
        .cnt_channel(cnt_channel), .cnt_valid(v1), .cnt_beats(b1), .cnt_bytes(y1),
        .cnt_packets(p1), .cnt_overflow(o1));

    logic_axi4_stream_transfer_counter #(.COUNTER_WIDTH(8), .SATURATE(0)) u2 (
        .aclk(aclk), .areset(areset), .rx(rxa[2]), .tx(txa[2]),
        .cnt_read(cnt_read), .cnt_clear(cnt_clear), .cnt_clear_all(cnt_clear_all),
        .cnt_channel(cnt_channel), .cnt_valid(v2), .cnt_beats(b2), .cnt_bytes(y2),
        .cnt_packets(p2), .cnt_overflow(o2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_pass();
        chk("tx_tvalid", txa[0].tvalid, s_tvalid);
        chk("tx_tdata",  txa[0].tdata,  s_tdata);
        chk("tx_tkeep",  txa[0].tkeep,  s_tkeep);
        chk("tx_tlast",  txa[0].tlast,  s_tlast);
        chk("tx_tdest",  txa[0].tdest,  s_tdest);
        chk("rx_tready", rxa[0].tready, s_tx_tready);
    endtask

    // Holds the beat until accepted; with toggle, tready alternates every cycle.
    task automatic beat(input logic [1:0] dest, input logic [3:0] keep, input logic last, input logic toggle);
        logic done;
        done     = 1'b0;
        s_tvalid = 1'b1;
        s_tdest  = dest;
        s_tkeep  = keep;
        s_tstrb  = keep;
        s_tlast  = last;
        s_tdata  = $urandom;
        for (int k = 0; k < 4 && !done; k++) begin
            s_tx_tready = toggle ? ~s_tx_tready : 1'b1;
            #1;
            if (toggle) chk_pass();
            done = s_tx_tready;
            @(posedge aclk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic packets3(input logic toggle);
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++)
                beat(2'd1, 4'hF, b == 3, toggle);
    endtask

    // Read request stays asserted on return so consecutive calls are back-to-back.
    task automatic rd(input logic [1:0] ch, input logic clr);
        cnt_read    = 1'b1;
        cnt_clear   = clr;
        cnt_channel = ch;
        tick();
        cnt_clear   = 1'b0;
    endtask

    task automatic chk_snap(input string tag, input logic [31:0] eb, input logic [31:0] ey,
                            input logic [31:0] ep, input logic eo);
        chk({tag, "_valid"}, v0, 1'b1);
        chk({tag, "_beats"}, b0, eb);
        chk({tag, "_bytes"}, y0, ey);
        chk({tag, "_pkts"},  p0, ep);
        chk({tag, "_ovf"},   o0, eo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        areset = 1'b1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 32'h0; s_tkeep = 4'h0; s_tstrb = 4'h0;
        s_tdest = 2'd0; s_tuser = 1'b0; s_tid = 1'b0; s_tx_tready = 1'b1;
        cnt_read = 1'b0; cnt_clear = 1'b0; cnt_clear_all = 1'b0; cnt_channel = 2'd0;
        repeat (3) tick();
        chk("rst_valid", v0, 1'b0);
        chk("rst_beats", b0, 32'd0);
        chk("rst_bytes", y0, 32'd0);
        chk("rst_pkts",  p0, 32'd0);
        chk("rst_ovf",   o0, 1'b0);
        s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF; s_tkeep = 4'h5; s_tdest = 2'd3; s_tx_tready = 1'b0;
        #1;
        chk_pass();
        s_tvalid = 1'b0; s_tx_tready = 1'b1;
        areset = 1'b0;
        tick();

        packets3(1'b0);
        rd(2'd1, 1'b0);
        chk_snap("ch1", 12, 48, 3, 1'b0);
        rd(2'd0, 1'b0);
        chk_snap("ch0", 0, 0, 0, 1'b0);
        rd(2'd2, 1'b0);
        chk_snap("ch2", 0, 0, 0, 1'b0);
        rd(2'd3, 1'b1);
        chk_snap("ch3", 0, 0, 0, 1'b0);
        cnt_read = 1'b0;
        tick();
        chk("valid_pulse_end", v0, 1'b0);
        chk("hold_beats", b0, 32'd0);

        rd(2'd1, 1'b1);
        chk_snap("ch1_clr", 12, 48, 3, 1'b0);
        cnt_read = 1'b0;
        packets3(1'b1);
        rd(2'd1, 1'b0);
        chk_snap("ch1_toggle", 12, 48, 3, 1'b0);
        cnt_read = 1'b0;

        for (int i = 0; i < 5; i++) beat(2'd2, 4'hF, 1'b0, 1'b0);
        s_tvalid = 1'b1; s_tdest = 2'd2; s_tkeep = 4'h3; s_tlast = 1'b1; s_tx_tready = 1'b1;
        rd(2'd2, 1'b1);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk_snap("ch2_rdclr", 6, 22, 1, 1'b0);
        rd(2'd2, 1'b0);
        chk_snap("ch2_after", 0, 0, 0, 1'b0);
        cnt_read = 1'b0;

        beat(2'd0, 4'h7, 1'b1, 1'b0);
        s_tvalid = 1'b1; s_tdest = 2'd3; s_tkeep = 4'h1; s_tlast = 1'b1; cnt_clear_all = 1'b1;
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0; cnt_clear_all = 1'b0;
        rd(2'd3, 1'b0);
        chk_snap("clrall_ch3", 1, 1, 1, 1'b0);
        rd(2'd0, 1'b0);
        chk_snap("clrall_ch0", 0, 0, 0, 1'b0);
        rd(2'd1, 1'b0);
        chk_snap("clrall_ch1", 0, 0, 0, 1'b0);
        cnt_read = 1'b0;

        areset = 1'b1;
        tick();
        areset = 1'b0;
        for (int i = 0; i < 70; i++) beat(2'd0, 4'hF, 1'b0, 1'b0);
        rd(2'd0, 1'b0);
        cnt_read = 1'b0;
        chk_snap("wide_ch0", 70, 280, 0, 1'b0);
        chk("sat_beats", b1, 8'd70);
        chk("sat_bytes", y1, 8'd255);
        chk("sat_ovf",   o1, 1'b1);
        chk("wrap_beats", b2, 8'd70);
        chk("wrap_bytes", y2, 8'd24);
        chk("wrap_ovf",   o2, 1'b1);
        chk("wrap_valid", v2, 1'b1);

        beat(2'd1, 4'hF, 1'b0, 1'b0);
        beat(2'd1, 4'hF, 1'b0, 1'b0);
        rd(2'd1, 1'b0);
        cnt_read = 1'b0;
        chk_snap("mid_pre", 2, 8, 0, 1'b0);
        #2;
        areset = 1'b1;
        #1;
        chk("mid_rst_valid", v0, 1'b0);
        chk("mid_rst_beats", b0, 32'd0);
        chk("mid_rst_bytes", y0, 32'd0);
        chk("mid_rst_pkts",  p0, 32'd0);
        tick();
        areset = 1'b0;
        beat(2'd1, 4'hF, 1'b0, 1'b0);
        beat(2'd1, 4'hF, 1'b1, 1'b0);
        rd(2'd1, 1'b0);
        cnt_read = 1'b0;
        chk_snap("mid_post", 2, 8, 1, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
